cpu_debug_scanner: RTL and testbench

- Initiator side of the pipeline CPU debug probe interface: drives `rf_addr`/`mem_addr` and samples `rf_data`/`mem_data` plus the per-stage PC taps.
- Replaces hand-stepping of probe addresses with an automatic dump sequence.
- Emits every sampled word as a tagged record on a valid/ready stream, which feeds the board display or host link.
- Sits beside `pipeline_cpu` on the same clock.

---
 rtl/cpu_debug_scanner.sv | 215 +++++++++++++++++++++
 tb/tb_cpu_debug_scanner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_scanner.sv
// Debug-probe dump sequencer: walks the RF and a memory window and streams tagged records.
// Define DBG_SCAN_PC_EN to append a six-record PC/stage-valid snapshot to every dump.
module cpu_debug_scanner #(
    parameter int unsigned RD_LAT    = 0,
    parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rf_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] rf_data,
    input  logic [31:0] mem_data,
    input  logic [31:0] IF_pc,
    input  logic [31:0] ID_pc,
    input  logic [31:0] EXE_pc,
    input  logic [31:0] MEM_pc,
    input  logic [31:0] WB_pc,
    input  logic [31:0] cpu_5_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_kind,
    output logic [7:0]  out_index,
    output logic [31:0] out_data
);

    typedef enum logic [3:0] {
        StIdle,
        StRfAddr,
        StRfWait,
        StRfOut,
        StMemAddr,
        StMemWait,
        StMemOut,
        StPcSnap,
        StPcOut,
        StFin
    } state_e;

    localparam logic [1:0] KindRf  = 2'd0;
    localparam logic [1:0] KindMem = 2'd1;
    localparam logic [1:0] KindPc  = 2'd2;
    localparam logic [8:0] RfLast  = 9'd31;
    localparam logic [8:0] MemLast = 9'(MEM_WORDS - 1);
    // Loaded on the ADDR cycle; only meaningful when RD_LAT > 0.
    localparam logic [3:0] WaitInit = 4'(RD_LAT - 1);

    state_e      state_q;
    logic [8:0]  idx_q;
    logic [3:0]  wait_cnt_q;
    logic        busy_q;
    logic        done_q;
    logic [4:0]  rf_addr_q;
    logic [31:0] mem_addr_q;
    logic        out_valid_q;
    logic [1:0]  out_kind_q;
    logic [7:0]  out_index_q;
    logic [31:0] out_data_q;

    logic [8:0]  idx_inc;
    logic [31:0] mem_addr_next;

    assign idx_inc       = idx_q + 9'd1;
    assign mem_addr_next = MEM_BASE + {21'd0, idx_inc, 2'b00};

`ifdef DBG_SCAN_PC_EN
    localparam logic [8:0] PcLast = 9'd5;
    logic [31:0] snap_q [6];
`else
    logic unused_pc;
    assign unused_pc = ^{IF_pc, ID_pc, EXE_pc, MEM_pc, WB_pc, cpu_5_valid};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            idx_q       <= 9'd0;
            wait_cnt_q  <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_addr_q   <= 5'd0;
            mem_addr_q  <= 32'd0;
            out_valid_q <= 1'b0;
            out_kind_q  <= 2'd0;
            out_index_q <= 8'd0;
            out_data_q  <= 32'd0;
`ifdef DBG_SCAN_PC_EN
            for (int i = 0; i < 6; i++) begin
                snap_q[i] <= 32'd0;
            end
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        idx_q     <= 9'd0;
                        rf_addr_q <= 5'd0;
                        busy_q    <= 1'b1;
                        state_q   <= StRfAddr;
                    end
                end
                StRfAddr, StRfWait: begin
                    if ((state_q == StRfAddr) ? (RD_LAT == 0) : (wait_cnt_q == 4'd0)) begin
                        out_valid_q <= 1'b1;
                        out_kind_q  <= KindRf;
                        out_index_q <= idx_q[7:0];
                        out_data_q  <= rf_data;
                        state_q     <= StRfOut;
                    end else begin
                        wait_cnt_q <= (state_q == StRfAddr) ? WaitInit : wait_cnt_q - 4'd1;
                        state_q    <= StRfWait;
                    end
                end
                StRfOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == RfLast) begin
                            idx_q      <= 9'd0;
                            mem_addr_q <= MEM_BASE;
                            state_q    <= StMemAddr;
                        end else begin
                            idx_q     <= idx_inc;
                            rf_addr_q <= idx_inc[4:0];
                            state_q   <= StRfAddr;
                        end
                    end
                end
                StMemAddr, StMemWait: begin
                    if ((state_q == StMemAddr) ? (RD_LAT == 0) : (wait_cnt_q == 4'd0)) begin
                        out_valid_q <= 1'b1;
                        out_kind_q  <= KindMem;
                        out_index_q <= idx_q[7:0];
                        out_data_q  <= mem_data;
                        state_q     <= StMemOut;
                    end else begin
                        wait_cnt_q <= (state_q == StMemAddr) ? WaitInit : wait_cnt_q - 4'd1;
                        state_q    <= StMemWait;
                    end
                end
                StMemOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (idx_q == MemLast) begin
`ifdef DBG_SCAN_PC_EN
                            idx_q   <= 9'd0;
                            state_q <= StPcSnap;
`else
                            done_q  <= 1'b1;
                            state_q <= StFin;
`endif
                        end else begin
                            idx_q      <= idx_inc;
                            mem_addr_q <= mem_addr_next;
                            state_q    <= StMemAddr;
                        end
                    end
                end
`ifdef DBG_SCAN_PC_EN
                StPcSnap: begin
                    // All six taps captured on one edge so the snapshot is coherent.
                    snap_q[0]   <= IF_pc;
                    snap_q[1]   <= ID_pc;
                    snap_q[2]   <= EXE_pc;
                    snap_q[3]   <= MEM_pc;
                    snap_q[4]   <= WB_pc;
                    snap_q[5]   <= cpu_5_valid;
                    out_valid_q <= 1'b1;
                    out_kind_q  <= KindPc;
                    out_index_q <= 8'd0;
                    out_data_q  <= IF_pc;
                    state_q     <= StPcOut;
                end
                StPcOut: begin
                    if (out_valid_q) begin
                        if (out_ready) begin
                            out_valid_q <= 1'b0;
                            if (idx_q == PcLast) begin
                                done_q  <= 1'b1;
                                state_q <= StFin;
                            end else begin
                                idx_q <= idx_inc;
                            end
                        end
                    end else begin
                        out_valid_q <= 1'b1;
                        out_index_q <= idx_q[7:0];
                        out_data_q  <= snap_q[idx_q[2:0]];
                    end
                end
`endif
                StFin: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rf_addr   = rf_addr_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_kind  = out_kind_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_cpu_debug_scanner.sv
// Scoreboard bench: a zero-latency scanner with stalls/aborts and a RD_LAT=3 scanner alongside.
module tb_cpu_debug_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn, start, start2, out_ready;
    logic        busy, done, out_valid;
    logic [4:0]  rf_addr;
    logic [31:0] mem_addr, rf_data, mem_data, out_data;
    logic [1:0]  out_kind;
    logic [7:0]  out_index;

    logic        busy2, done2, out_valid2;
    logic [4:0]  rf_addr2;
    logic [31:0] mem_addr2, rf_data2, mem_data2, out_data2;
    logic [1:0]  out_kind2;
    logic [7:0]  out_index2;

    logic [31:0] if_pc, id_pc, exe_pc, mem_pc, wb_pc, stage_valid;
    assign if_pc       = 32'h0000_0100;
    assign id_pc       = 32'h0000_00FC;
    assign exe_pc      = 32'h0000_00F8;
    assign mem_pc      = 32'h0000_00F4;
    assign wb_pc       = 32'h0000_00F0;
    assign stage_valid = 32'h0000_001F;

    logic [31:0] pc_tab [6] = '{32'h100, 32'hFC, 32'hF8, 32'hF4, 32'hF0, 32'h1F};

`ifdef DBG_SCAN_PC_EN
    localparam int NRec = 42;
`else
    localparam int NRec = 36;
`endif

    function automatic logic [31:0] rf_val(input logic [4:0] a);
        return 32'(a) * 32'h1111_1111;
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a >= 32'h40 && a < 32'h50) return 32'hA0 + ((a - 32'h40) >> 2);
        return 32'hDEAD_0000 ^ a;
    endfunction

    // Second DUT only sees good RF data once the address has been stable for 4 negedges.
    int          stab2 = 0;
    logic [4:0]  last_rf2 = 5'd0;
    assign rf_data   = rf_val(rf_addr);
    assign mem_data  = mem_val(mem_addr);
    assign rf_data2  = (stab2 >= 4) ? rf_val(rf_addr2) : 32'hBAD0_BAD0;
    assign mem_data2 = mem_val(mem_addr2);

    cpu_debug_scanner #(.RD_LAT(0), .MEM_BASE(32'h40), .MEM_WORDS(4)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .rf_addr(rf_addr), .mem_addr(mem_addr), .rf_data(rf_data), .mem_data(mem_data),
        .IF_pc(if_pc), .ID_pc(id_pc), .EXE_pc(exe_pc), .MEM_pc(mem_pc), .WB_pc(wb_pc),
        .cpu_5_valid(stage_valid), .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_index(out_index), .out_data(out_data)
    );

    cpu_debug_scanner #(.RD_LAT(3), .MEM_BASE(32'h40), .MEM_WORDS(4)) u_dut_lat3 (
        .clk(clk), .resetn(resetn), .start(start2), .busy(busy2), .done(done2),
        .rf_addr(rf_addr2), .mem_addr(mem_addr2), .rf_data(rf_data2), .mem_data(mem_data2),
        .IF_pc(if_pc), .ID_pc(id_pc), .EXE_pc(exe_pc), .MEM_pc(mem_pc), .WB_pc(wb_pc),
        .cpu_5_valid(stage_valid), .out_valid(out_valid2), .out_ready(1'b1),
        .out_kind(out_kind2), .out_index(out_index2), .out_data(out_data2)
    );

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  idx;
        logic [31:0] data;
    } rec_t;

    rec_t exp_q[$];
    rec_t exp_r;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_hs = 0;
    int   n_rec = 0;
    int   done_cnt = 0;
    bit   skip_gap = 1'b1;
    int   n_rec2 = 0;
    int   done2_cnt = 0;
    int   last2 = 0;
    bit   first2 = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_dump();
        for (int i = 0; i < 32; i++) exp_q.push_back('{2'd0, 8'(i), rf_val(5'(i))});
        for (int i = 0; i < 4; i++) exp_q.push_back('{2'd1, 8'(i), 32'hA0 + 32'(i)});
`ifdef DBG_SCAN_PC_EN
        for (int i = 0; i < 6; i++) exp_q.push_back('{2'd2, 8'(i), pc_tab[i]});
`endif
    endtask

    // Monitor for the main DUT: pops one expectation per handshake.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (resetn && out_valid && out_ready) begin
            n_rec++;
            check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                exp_r = exp_q.pop_front();
                check("rec_kind", 32'(out_kind), 32'(exp_r.kind));
                check("rec_index", 32'(out_index), 32'(exp_r.idx));
                check("rec_data", out_data, exp_r.data);
                if (exp_r.kind == 2'd0) check("rf_addr", 32'(rf_addr), 32'(exp_r.idx[4:0]));
                if (exp_r.kind == 2'd1)
                    check("mem_addr", mem_addr, 32'h40 + 32'(exp_r.idx) * 4);
                if (!skip_gap && !(exp_r.kind == 2'd0 && exp_r.idx == 8'd5))
                    check("rec_gap", 32'(cyc - last_hs), 32'd2);
            end
            skip_gap = 1'b0;
            last_hs = cyc;
        end
    end

    // Monitor for the RD_LAT=3 DUT: expectation derived from the record ordinal.
    always @(negedge clk) begin
        logic [31:0] e_data;
        logic [1:0]  e_kind;
        logic [7:0]  e_idx;
        if (rf_addr2 == last_rf2) stab2++;
        else stab2 = 1;
        last_rf2 = rf_addr2;
        if (done2) done2_cnt++;
        if (resetn && out_valid2) begin
            if (n_rec2 < 32) begin
                e_kind = 2'd0; e_idx = 8'(n_rec2); e_data = rf_val(5'(n_rec2));
            end else if (n_rec2 < 36) begin
                e_kind = 2'd1; e_idx = 8'(n_rec2 - 32); e_data = 32'hA0 + 32'(n_rec2 - 32);
            end else begin
                e_kind = 2'd2; e_idx = 8'(n_rec2 - 36); e_data = pc_tab[(n_rec2 - 36) % 6];
            end
            check("lat3_kind", 32'(out_kind2), 32'(e_kind));
            check("lat3_index", 32'(out_index2), 32'(e_idx));
            check("lat3_data", out_data2, e_data);
            if (!first2 && e_kind != 2'd2) check("lat3_gap", 32'(cyc - last2), 32'd5);
            first2 = 1'b0;
            last2 = cyc;
            n_rec2++;
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_rec(input logic [1:0] k, input logic [7:0] i);
        bit ok = 1'b0;
        for (int c = 0; c < 400 && !ok; c++) begin
            @(posedge clk); #1;
            if (out_valid && out_kind == k && out_index == i) ok = 1'b1;
        end
        check("wait_rec_seen", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input bit fin_start);
        bit ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(posedge clk); #1;
            if (done) begin
                ok = 1'b1;
                if (fin_start) start = 1'b1;
            end
        end
        check("done_seen", 32'(ok), 32'd1);
        @(posedge clk); #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("record_count", 32'(n_rec), 32'(NRec));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic new_dump();
        push_dump();
        done_cnt = 0;
        n_rec = 0;
        skip_gap = 1'b1;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; start2 = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rf_addr", 32'(rf_addr), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_out_kind", 32'(out_kind), 32'd0);
        check("rst_out_index", 32'(out_index), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        resetn = 1'b1;

        // Dump 1 with a 10-cycle stall on RF record 5; the RD_LAT=3 DUT runs alongside.
        new_dump();
        @(posedge clk); #1 start = 1'b1; start2 = 1'b1;
        @(posedge clk); #1 start = 1'b0; start2 = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        wait_rec(2'd0, 8'd5);
        out_ready = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_index", 32'(out_index), 32'd5);
            check("stall_data", out_data, 32'h5555_5555);
            check("stall_rf_addr", 32'(rf_addr), 32'd5);
        end
        out_ready = 1'b1;
        wait_done(1'b0);

        // Dump 2: starts while busy and in the FIN cycle must be ignored.
        new_dump();
        pulse_start();
        repeat (5) @(posedge clk);
        pulse_start();
        repeat (7) @(posedge clk);
        pulse_start();
        wait_done(1'b1);

        begin : wait_lat3
            for (int c = 0; c < 1000 && done2_cnt == 0; c++) @(posedge clk);
            #1;
            check("lat3_done", 32'(done2_cnt), 32'd1);
            check("lat3_count", 32'(n_rec2), 32'(NRec));
        end

        // Dump 3 aborted by reset during MEM record 2.
        new_dump();
        pulse_start();
        wait_rec(2'd1, 8'd2);
        resetn = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rf_addr", 32'(rf_addr), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_out_kind", 32'(out_kind), 32'd0);
        check("abort_out_index", 32'(out_index), 32'd0);
        check("abort_out_data", out_data, 32'd0);
        exp_q.delete();
        @(posedge clk); #1 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_auto_restart", 32'(busy | out_valid), 32'd0);

        // Dump 4: full restart from RF index 0.
        new_dump();
        pulse_start();
        wait_done(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
